// File: rtl/udp_payload_fifo.sv
// Packet-mode store-and-forward FIFO for the UDP payload stream; only whole packets reach the output.
// Define FIFO_STATS_EN to add the saturating pkt_count/drop_count outputs.
module udp_payload_fifo #(
    parameter int DEPTH = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic       in_abort,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       drop_pulse
`ifdef FIFO_STATS_EN
    ,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count
`endif
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, WRITE, DISCARD} wr_state_e;

    wr_state_e          state_q, state_d;
    logic [PTR_W-1:0]   wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
    logic               drop_q, drop_d;
    logic               we, commit_evt, full;
    logic [PTR_W-1:0]   occupancy;

    logic [8:0]         mem_q [DEPTH];
    logic [8:0]         ram_dout_q;
    logic               ram_valid_q, ram_valid_d;
    logic [8:0]         out_word_q, out_word_d;
    logic               out_valid_q, out_valid_d;
    logic               pop, load_out, rd_en;

    // rd_q advances at read issue, so bytes in flight or in the output register count as free
    assign occupancy = wr_q - rd_q;
    assign full      = (occupancy == PTR_W'(DEPTH));

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        commit_d   = commit_q;
        drop_d     = 1'b0;
        we         = 1'b0;
        commit_evt = 1'b0;
        if (in_abort) begin
            wr_d    = commit_q;
            state_d = IDLE;
            drop_d  = (state_q != IDLE);
        end else if (in_valid) begin
            case (state_q)
                IDLE, WRITE: begin
                    if (!full) begin
                        we   = 1'b1;
                        wr_d = wr_q + PTR_W'(1);
                        if (in_last) begin
                            commit_d   = wr_q + PTR_W'(1);
                            commit_evt = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = WRITE;
                        end
                    end else if (in_last) begin
                        wr_d    = commit_q;
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (in_last) begin
                        wr_d    = commit_q;
                        drop_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Two-stage read: RAM output stage feeding a one-entry output register
    always_comb begin
        pop         = out_valid_q && out_ready;
        load_out    = ram_valid_q && (!out_valid_q || pop);
        rd_en       = (rd_q != commit_q) && (!ram_valid_q || load_out);
        rd_d        = rd_en ? rd_q + PTR_W'(1) : rd_q;
        ram_valid_d = rd_en ? 1'b1 : (load_out ? 1'b0 : ram_valid_q);
        out_valid_d = load_out ? 1'b1 : (pop ? 1'b0 : out_valid_q);
        out_word_d  = load_out ? ram_dout_q : out_word_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            commit_q    <= '0;
            rd_q        <= '0;
            drop_q      <= 1'b0;
            ram_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            commit_q    <= commit_d;
            rd_q        <= rd_d;
            drop_q      <= drop_d;
            ram_valid_q <= ram_valid_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we)
            mem_q[wr_q[ADDR_W-1:0]] <= {in_last, in_data};
        if (rd_en)
            ram_dout_q <= mem_q[rd_q[ADDR_W-1:0]];
    end

    assign out_data   = out_word_q[7:0];
    assign out_last   = out_word_q[8];
    assign out_valid  = out_valid_q;
    assign drop_pulse = drop_q;

`ifdef FIFO_STATS_EN
    logic [15:0] pkt_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (commit_evt && pkt_cnt_q != 16'hFFFF)
                pkt_cnt_q <= pkt_cnt_q + 16'd1;
            if (drop_q && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign pkt_count  = pkt_cnt_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_udp_payload_fifo.sv
// Directed bench for udp_payload_fifo (DEPTH=16) with hand-computed expectations.
// Build with FIFO_STATS_EN defined to also check the packet/drop counters.
module tb_udp_payload_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_abort;
    logic [7:0] out_data;
    logic       out_valid, out_last, out_ready;
    logic       drop_pulse;
`ifdef FIFO_STATS_EN
    logic [15:0] pkt_count, drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    udp_payload_fifo #(.DEPTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_abort   (in_abort),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .drop_pulse (drop_pulse)
`ifdef FIFO_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic [7:0] exp_d [6];
    logic       exp_l [6];
    logic [7:0] held;
    int         idx;

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 0; in_last = 0; in_abort = 0; out_ready = 0;
        #12;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", {8'd0, out_data}, 16'd0);
        chk("rst_drop", {15'd0, drop_pulse}, 16'd0);
        reset = 1'b0;
        tick();

        // 4-byte packet, latency and ordering
        out_ready = 1'b1;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
        chk("lat_e0_valid", {15'd0, out_valid}, 16'd0);
        tick();
        chk("lat_e1_valid", {15'd0, out_valid}, 16'd0);
        tick();
        chk("p1_valid0", {15'd0, out_valid}, 16'd1);
        chk("p1_b0", {8'd0, out_data}, 16'h11);
        chk("p1_l0", {15'd0, out_last}, 16'd0);
        tick();
        chk("p1_b1", {8'd0, out_data}, 16'h22);
        chk("p1_l1", {15'd0, out_last}, 16'd0);
        chk("p1_drop", {15'd0, drop_pulse}, 16'd0);
        tick();
        chk("p1_b2", {8'd0, out_data}, 16'h33);
        tick();
        chk("p1_b3", {8'd0, out_data}, 16'h44);
        chk("p1_l3", {15'd0, out_last}, 16'd1);
        chk("p1_v3", {15'd0, out_valid}, 16'd1);
        tick();
        chk("p1_end_valid", {15'd0, out_valid}, 16'd0);
        chk("p1_end_drop", {15'd0, drop_pulse}, 16'd0);

        // 20-byte packet overflows a 16-deep buffer
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(8'(i + 1), (i == 19));
            if (i < 19) chk("ovf_nodrop", {15'd0, drop_pulse}, 16'd0);
        end
        chk("ovf_drop", {15'd0, drop_pulse}, 16'd1);
        chk("ovf_valid", {15'd0, out_valid}, 16'd0);
        tick();
        chk("ovf_drop_once", {15'd0, drop_pulse}, 16'd0);
        send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 1);
        tick(); tick();
        chk("p2_valid", {15'd0, out_valid}, 16'd1);
        chk("p2_b0", {8'd0, out_data}, 16'hA1);
        tick();
        chk("p2_hold", {8'd0, out_data}, 16'hA1);
        out_ready = 1'b1;
        tick();
        chk("p2_b1", {8'd0, out_data}, 16'hA2);
        tick();
        chk("p2_b2", {8'd0, out_data}, 16'hA3);
        chk("p2_l2", {15'd0, out_last}, 16'd1);
        tick();
        chk("p2_end", {15'd0, out_valid}, 16'd0);

        // abort after 5 bytes
        for (int i = 0; i < 5; i++) send(8'h51 + 8'(i), 0);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        chk("abort_drop", {15'd0, drop_pulse}, 16'd1);
        tick();
        chk("abort_drop_once", {15'd0, drop_pulse}, 16'd0);
        chk("abort_novalid", {15'd0, out_valid}, 16'd0);
        send(8'hAA, 0); send(8'hBB, 1);
        tick(); tick();
        chk("p3_b0", {8'd0, out_data}, 16'hAA);
        chk("p3_l0", {15'd0, out_last}, 16'd0);
        tick();
        chk("p3_b1", {8'd0, out_data}, 16'hBB);
        chk("p3_l1", {15'd0, out_last}, 16'd1);
        tick();
        chk("p3_end", {15'd0, out_valid}, 16'd0);

        // 1, 2, 3 byte packets read out with out_ready toggling
        out_ready = 1'b0;
        send(8'h01, 1); send(8'h02, 0); send(8'h03, 1);
        send(8'h04, 0); send(8'h05, 0); send(8'h06, 1);
        exp_d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        exp_l = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        idx = 0;
        for (int c = 0; c < 40 && idx < 6; c++) begin
            out_ready = c[0];
            if (out_valid && out_ready) begin
                chk("seq_data", {8'd0, out_data}, {8'd0, exp_d[idx]});
                chk("seq_last", {15'd0, out_last}, {15'd0, exp_l[idx]});
                idx++;
                tick();
            end else if (out_valid) begin
                held = out_data;
                tick();
                chk("seq_stall_hold", {8'd0, out_data}, {8'd0, held});
            end else begin
                tick();
            end
        end
        chk("seq_count", 16'(idx), 16'd6);
        out_ready = 1'b0;
        tick();
        chk("seq_empty", {15'd0, out_valid}, 16'd0);
`ifdef FIFO_STATS_EN
        chk("stat_pkt", pkt_count, 16'd6);
        chk("stat_drop", drop_count, 16'd2);
`endif

        // reset during both a read and a write
        send(8'h61, 0); send(8'h62, 1);
        tick(); tick();
        chk("pre_rst_valid", {15'd0, out_valid}, 16'd1);
        in_data = 8'h71; in_valid = 1'b1;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_data", {8'd0, out_data}, 16'd0);
        chk("mid_rst_last", {15'd0, out_last}, 16'd0);
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        send(8'h81, 0); send(8'h82, 1);
        tick(); tick();
        chk("p5_b0", {8'd0, out_data}, 16'h81);
        chk("p5_v0", {15'd0, out_valid}, 16'd1);
        tick();
        chk("p5_b1", {8'd0, out_data}, 16'h82);
        chk("p5_l1", {15'd0, out_last}, 16'd1);
        tick();
        chk("p5_end", {15'd0, out_valid}, 16'd0);
`ifdef FIFO_STATS_EN
        chk("stat_pkt_post_rst", pkt_count, 16'd1);
        chk("stat_drop_post_rst", drop_count, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
